instruction_fetch_unit: RTL and testbench

Pipeline front end: owns the fetch PC, issues one-outstanding requests to instruction memory, buffers a returned word while the pipeline is stalled, and drives the IF/ID pipeline register consumed by decode and the hazard detection unit (`id_pc` feeds its `ID_PC`). It obeys the hazard unit's fetch stall, decode stall and flush outputs, and the branch/trap redirects from EX/MEM.

---
 rtl/instruction_fetch_unit.sv | 179 +++++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Pipeline front end: owns the fetch PC, keeps one instruction-memory request
// outstanding, parks a returned word across stalls and drives the IF/ID register.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_if,
    input  logic        stall_id,
    input  logic        flush_id,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        trap_valid,
    input  logic [31:0] trap_pc,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        imem_resp_err,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic        id_misaligned,
    output logic        id_fault
);

    typedef enum logic [1:0] {
        ST_ISSUE,
        ST_WAIT,
        ST_HOLD,
        ST_DISCARD
    } state_t;

    state_t      state, state_next;
    logic [31:0] fetch_pc, fetch_pc_next;
    logic [31:0] req_pc;
    logic [31:0] buf_instr;
    logic        buf_err;

    logic        redirect;
    logic [31:0] target;
    logic        hold;
    logic        req_fire;
    logic        capture;

    logic        deliver;
    logic [31:0] dlv_pc;
    logic [31:0] dlv_instr;
    logic        dlv_err;
    logic        dlv_mis;

    // Trap outranks a simultaneous branch redirect.
    assign redirect = trap_valid | redirect_valid;
    assign target   = trap_valid ? trap_pc : redirect_pc;
    assign hold     = stall_if | stall_id;

    assign imem_req_valid = ~reset & (state == ST_ISSUE) & ~hold & ~redirect
                          & (fetch_pc[1:0] == 2'b00);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid & imem_req_ready;

    always_comb begin
        state_next    = state;
        fetch_pc_next = fetch_pc;
        capture       = 1'b0;
        deliver       = 1'b0;
        dlv_pc        = req_pc;
        dlv_instr     = imem_resp_data;
        dlv_err       = imem_resp_err;
        dlv_mis       = 1'b0;

        if (redirect) begin
            fetch_pc_next = target;
        end

        case (state)
            ST_ISSUE: begin
                if (!redirect) begin
                    // A misaligned PC never reaches memory; it keeps presenting a
                    // faulting bubble until a trap redirect moves the PC away.
                    if (fetch_pc[1:0] != 2'b00) begin
                        if (!hold) begin
                            deliver   = 1'b1;
                            dlv_pc    = fetch_pc;
                            dlv_instr = NOP_INSTR;
                            dlv_err   = 1'b0;
                            dlv_mis   = 1'b1;
                        end
                    end else if (req_fire) begin
                        state_next = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    state_next = imem_resp_valid ? ST_ISSUE : ST_DISCARD;
                end else if (imem_resp_valid) begin
                    if (hold) begin
                        capture    = 1'b1;
                        state_next = ST_HOLD;
                    end else begin
                        deliver       = 1'b1;
                        fetch_pc_next = req_pc + 32'd4;
                        state_next    = ST_ISSUE;
                    end
                end
            end
            ST_HOLD: begin
                if (redirect) begin
                    state_next = ST_ISSUE;
                end else if (!hold) begin
                    deliver       = 1'b1;
                    dlv_instr     = buf_instr;
                    dlv_err       = buf_err;
                    fetch_pc_next = req_pc + 32'd4;
                    state_next    = ST_ISSUE;
                end
            end
            ST_DISCARD: begin
                if (imem_resp_valid) begin
                    state_next = ST_ISSUE;
                end
            end
            default: state_next = ST_ISSUE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_ISSUE;
            fetch_pc  <= RESET_PC;
            req_pc    <= '0;
            buf_instr <= '0;
            buf_err   <= 1'b0;
        end else begin
            state    <= state_next;
            fetch_pc <= fetch_pc_next;
            if (req_fire) begin
                req_pc <= fetch_pc;
            end
            if (capture) begin
                buf_instr <= imem_resp_data;
                buf_err   <= imem_resp_err;
            end
        end
    end

    // IF/ID register; a bubble leaves id_pc untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            id_valid      <= 1'b0;
            id_pc         <= '0;
            id_instr      <= NOP_INSTR;
            id_misaligned <= 1'b0;
            id_fault      <= 1'b0;
        end else if (redirect || flush_id) begin
            id_valid      <= 1'b0;
            id_instr      <= NOP_INSTR;
            id_misaligned <= 1'b0;
            id_fault      <= 1'b0;
        end else if (stall_id) begin
            id_valid      <= id_valid;
        end else if (deliver) begin
            id_valid      <= 1'b1;
            id_pc         <= dlv_pc;
            id_instr      <= dlv_err ? NOP_INSTR : dlv_instr;
            id_misaligned <= dlv_mis;
            id_fault      <= dlv_err;
        end else begin
            id_valid      <= 1'b0;
            id_instr      <= NOP_INSTR;
            id_misaligned <= 1'b0;
            id_fault      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios then random traffic,
// every cycle compared with a transaction-level model of the fetch front end.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset, stall_if, stall_id, flush_id;
    logic        redirect_valid, trap_valid;
    logic [31:0] redirect_pc, trap_pc;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_resp_valid, imem_resp_err;
    logic [31:0] imem_resp_data;
    logic        id_valid, id_misaligned, id_fault;
    logic [31:0] id_pc, id_instr;

    instruction_fetch_unit #(
        .RESET_PC (RST_PC),
        .NOP_INSTR(NOP)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .flush_id       (flush_id),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .trap_valid     (trap_valid),
        .trap_pc        (trap_pc),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .imem_resp_err  (imem_resp_err),
        .id_valid       (id_valid),
        .id_pc          (id_pc),
        .id_instr       (id_instr),
        .id_misaligned  (id_misaligned),
        .id_fault       (id_fault)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    // Memory side: a single outstanding access with a countdown to its response.
    bit rand_mode = 1'b0;
    bit force_err = 1'b0;
    int dir_lat   = 1;
    bit mem_busy  = 1'b0;
    int mem_wait  = 0;

    // Reference model: where fetch goes next, whether an access is in flight and
    // wanted, whether a returned word is parked, and what IF/ID should show.
    logic [31:0] m_pc, m_flight_pc, m_park_word;
    bit          m_flight, m_keep, m_parked, m_park_err;
    logic        e_valid, e_mis, e_fault;
    logic [31:0] e_pc, e_instr;

    logic        obs_req;
    logic [31:0] obs_addr;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst, input bit sif, input bit sid, input bit fl,
                         input bit rv, input logic [31:0] rpc,
                         input bit tv, input logic [31:0] tpc);
        bit          hold, redir, exp_req, hand, dlv, d_err, d_mis;
        logic [31:0] tgt, d_pc, d_word;
        @(negedge clk);
        reset          = rst;
        stall_if       = sif;
        stall_id       = sid;
        flush_id       = fl;
        redirect_valid = rv;
        redirect_pc    = rpc;
        trap_valid     = tv;
        trap_pc        = tpc;
        imem_req_ready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
        imem_resp_data = $urandom;
        imem_resp_err  = force_err | (rand_mode && $urandom_range(0, 15) == 0);
        imem_resp_valid = 1'b0;
        if (rst) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            mem_wait--;
            if (mem_wait == 0) begin
                imem_resp_valid = 1'b1;
                mem_busy = 1'b0;
            end
        end

        hold    = sif | sid;
        redir   = rv | tv;
        tgt     = tv ? tpc : rpc;
        exp_req = !rst && !m_flight && !m_parked && !hold && !redir && (m_pc[1:0] == 2'b00);
        #1;
        obs_req  = imem_req_valid;
        obs_addr = imem_req_addr;
        check("req_valid", {31'b0, obs_req}, {31'b0, exp_req});
        if (!rst) check("req_addr", obs_addr, m_pc);
        hand = exp_req && imem_req_ready;

        dlv = 1'b0; d_err = 1'b0; d_mis = 1'b0; d_pc = '0; d_word = NOP;
        if (rst) begin
            m_pc = RST_PC; m_flight = 0; m_keep = 0; m_parked = 0;
            e_valid = 0; e_pc = '0; e_instr = NOP; e_mis = 0; e_fault = 0;
        end else begin
            if (redir) begin
                m_pc = tgt;
                m_parked = 0;
                if (m_flight) begin
                    if (imem_resp_valid) m_flight = 0;
                    else m_keep = 0;
                end
            end else if (m_parked) begin
                if (!hold) begin
                    dlv = 1; d_pc = m_flight_pc; d_word = m_park_word; d_err = m_park_err;
                    m_pc = m_flight_pc + 4; m_parked = 0;
                end
            end else if (m_flight) begin
                if (imem_resp_valid) begin
                    m_flight = 0;
                    if (m_keep) begin
                        if (hold) begin
                            m_parked = 1; m_park_word = imem_resp_data; m_park_err = imem_resp_err;
                        end else begin
                            dlv = 1; d_pc = m_flight_pc; d_word = imem_resp_data; d_err = imem_resp_err;
                            m_pc = m_flight_pc + 4;
                        end
                    end
                end
            end else if (m_pc[1:0] != 2'b00) begin
                if (!hold) begin
                    dlv = 1; d_pc = m_pc; d_mis = 1;
                end
            end else if (hand) begin
                m_flight = 1; m_keep = 1; m_flight_pc = m_pc;
            end

            if (redir || fl || (!sid && !dlv)) begin
                e_valid = 0; e_instr = NOP; e_mis = 0; e_fault = 0;
            end else if (!sid) begin
                e_valid = 1; e_pc = d_pc; e_instr = d_err ? NOP : d_word;
                e_mis = d_mis; e_fault = d_err;
            end
        end

        @(posedge clk);
        #1;
        if (hand) begin
            mem_busy = 1'b1;
            mem_wait = rand_mode ? int'($urandom_range(1, 3)) : dir_lat;
        end
        check("id_valid", {31'b0, id_valid}, {31'b0, e_valid});
        check("id_pc", id_pc, e_pc);
        check("id_instr", id_instr, e_instr);
        check("id_misaligned", {31'b0, id_misaligned}, {31'b0, e_mis});
        check("id_fault", {31'b0, id_fault}, {31'b0, e_fault});
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, '0, 0, '0);
    endtask

    initial begin
        bit          r_rst, r_sif, r_sid, r_fl, r_rv, r_tv;
        logic [31:0] r_rpc, r_tpc;

        cycle(1, 0, 0, 0, 0, '0, 0, '0);
        cycle(1, 0, 0, 0, 0, '0, 0, '0);
        check("reset_pc", id_pc, 32'h0);
        check("reset_instr", id_instr, NOP);

        // Zero-wait memory, no stalls: 0x100 then 0x104.
        idle();
        check("first_req_addr", obs_addr, 32'h100);
        idle();
        check("deliver_100_pc", id_pc, 32'h100);
        check("deliver_100_valid", {31'b0, id_valid}, 32'd1);
        idle();
        check("req_104", obs_addr, 32'h104);

        // Response for 0x104 lands during a three-cycle decode stall.
        repeat (3) begin
            cycle(0, 0, 1, 0, 0, '0, 0, '0);
            check("stall_hold_pc", id_pc, 32'h100);
            check("stall_no_req", {31'b0, obs_req}, 32'd0);
        end
        idle();
        check("after_stall_pc", id_pc, 32'h104);
        check("after_stall_valid", {31'b0, id_valid}, 32'd1);

        // Redirect while 0x108 is in flight; its late response is thrown away.
        dir_lat = 2;
        idle();
        check("req_108", obs_addr, 32'h108);
        cycle(0, 0, 0, 0, 1, 32'h200, 0, '0);
        check("redirect_bubble", {31'b0, id_valid}, 32'd0);
        idle();
        check("discard_no_req", {31'b0, obs_req}, 32'd0);
        dir_lat = 1;
        idle();
        check("req_200", obs_addr, 32'h200);
        idle();
        check("deliver_200", id_pc, 32'h200);

        // Trap beats a same-cycle branch.
        cycle(0, 0, 0, 0, 1, 32'h300, 1, 32'h80);
        idle();
        check("req_trap_80", obs_addr, 32'h80);
        check("req_trap_valid", {31'b0, obs_req}, 32'd1);
        idle();

        // Misaligned target.
        cycle(0, 0, 0, 0, 1, 32'h202, 0, '0);
        idle();
        check("mis_no_req", {31'b0, obs_req}, 32'd0);
        check("mis_pc", id_pc, 32'h202);
        check("mis_flag", {31'b0, id_misaligned}, 32'd1);
        check("mis_instr", id_instr, 32'h13);
        check("mis_valid", {31'b0, id_valid}, 32'd1);

        // Access fault at 0x10C, then flushed.
        cycle(0, 0, 0, 0, 0, '0, 1, 32'h10C);
        force_err = 1'b1;
        idle();
        idle();
        force_err = 1'b0;
        check("fault_flag", {31'b0, id_fault}, 32'd1);
        check("fault_instr", id_instr, 32'h13);
        check("fault_valid", {31'b0, id_valid}, 32'd1);
        check("fault_pc", id_pc, 32'h10C);
        cycle(0, 0, 0, 1, 0, '0, 0, '0);
        check("flush_valid", {31'b0, id_valid}, 32'd0);
        check("flush_fault", {31'b0, id_fault}, 32'd0);

        // Random traffic: stalls, flushes, redirects, traps, resets, slow memory.
        rand_mode = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            r_rst = ($urandom_range(0, 199) == 0);
            r_sif = ($urandom_range(0, 4) == 0);
            r_sid = ($urandom_range(0, 4) == 0);
            r_fl  = ($urandom_range(0, 9) == 0);
            r_rv  = ($urandom_range(0, 11) == 0);
            r_tv  = ($urandom_range(0, 24) == 0);
            r_rpc = $urandom;
            r_tpc = $urandom;
            if ($urandom_range(0, 7) != 0) r_rpc[1:0] = 2'b00;
            if ($urandom_range(0, 7) != 0) r_tpc[1:0] = 2'b00;
            cycle(r_rst, r_sif, r_sid, r_fl, r_rv, r_rpc, r_tv, r_tpc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
